// File: rtl/pulse_generator_if.sv
// ---------------------------------------------------------------------------
// pulse_generator_if : trigger/config/status bundle for pulse_generator
// Revision 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

interface pulse_generator_if #(
    parameter int DLY_W = 8,
    parameter int WID_W = 8
) ();
    logic             pos_neg;
    logic             iTrig;
    logic [DLY_W-1:0] iDelay;
    logic [WID_W-1:0] iWidth;
    logic             iClrOvf;
    logic             oPulse;
    logic             oBusy;
    logic             oDone;
    logic             oOverflow;

    modport master (
        output pos_neg, iTrig, iDelay, iWidth, iClrOvf,
        input  oPulse, oBusy, oDone, oOverflow
    );

    modport slave (
        input  pos_neg, iTrig, iDelay, iWidth, iClrOvf,
        output oPulse, oBusy, oDone, oOverflow
    );
endinterface

`default_nettype wire

// File: rtl/pulse_generator.sv
// ---------------------------------------------------------------------------
// pulse_generator : turns trigger strobes into delayed, timed output pulses
//                   with queued replay. Optional macro PULSE_GEN_RETRIGGER_EN
//                   lets a trigger during the pulse extend it.
// Revision 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module pulse_generator #(
    parameter int DLY_W   = 8,
    parameter int WID_W   = 8,
    parameter int MIN_GAP = 1,
    parameter int PEND_W  = 2
) (
    input  wire logic        iClk,
    input  wire logic        iRst_n,
    pulse_generator_if.slave pg
);

    localparam int                c_GAP_W    = (MIN_GAP > 0) ? $clog2(MIN_GAP + 1) : 1;
    localparam logic [c_GAP_W-1:0] c_GAP_LOAD = c_GAP_W'(MIN_GAP);
    localparam bit                c_HAS_GAP  = (MIN_GAP > 0);
    localparam logic [PEND_W-1:0] c_PEND_MAX = {PEND_W{1'b1}};

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DELAY  = 2'd1,
        S_ACTIVE = 2'd2,
        S_GAP    = 2'd3
    } state_t;

    state_t             r_state;
    logic               r_active;
    logic [DLY_W-1:0]   r_dly_cnt;
    logic [WID_W-1:0]   r_wid_cnt;
    logic [WID_W-1:0]   r_wid_lat;
    logic [c_GAP_W-1:0] r_gap_cnt;
    logic [PEND_W-1:0]  r_pend;
    logic               r_done;
    logic               r_ovf;
    logic               r_busy;

    state_t             w_state_nxt;
    logic               w_active_nxt;
    logic [DLY_W-1:0]   w_dly_nxt;
    logic [WID_W-1:0]   w_wid_nxt;
    logic [WID_W-1:0]   w_wlat_nxt;
    logic [c_GAP_W-1:0] w_gap_nxt;
    logic [PEND_W-1:0]  w_pend_nxt;
    logic               w_done_nxt;
    logic               w_ovf_nxt;
    logic               w_accept;
    logic               w_queue;
    logic               w_lose;
    logic               w_retrig;
    logic [WID_W-1:0]   w_wid_eff;

    assign w_wid_eff = (pg.iWidth == '0) ? WID_W'(1) : pg.iWidth;

`ifdef PULSE_GEN_RETRIGGER_EN
    assign w_retrig = pg.iTrig;
`else
    assign w_retrig = 1'b0;
`endif

    always_ff @(posedge iClk) begin
        if (!iRst_n) begin
            r_state   <= S_IDLE;
            r_active  <= 1'b0;
            r_dly_cnt <= '0;
            r_wid_cnt <= '0;
            r_wid_lat <= '0;
            r_gap_cnt <= '0;
            r_pend    <= '0;
            r_done    <= 1'b0;
            r_ovf     <= 1'b0;
            r_busy    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_active  <= w_active_nxt;
            r_dly_cnt <= w_dly_nxt;
            r_wid_cnt <= w_wid_nxt;
            r_wid_lat <= w_wlat_nxt;
            r_gap_cnt <= w_gap_nxt;
            r_pend    <= w_pend_nxt;
            r_done    <= w_done_nxt;
            r_ovf     <= w_ovf_nxt;
            r_busy    <= (w_state_nxt != S_IDLE) || (w_pend_nxt != '0);
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_active_nxt = r_active;
        w_dly_nxt    = r_dly_cnt;
        w_wid_nxt    = r_wid_cnt;
        w_wlat_nxt   = r_wid_lat;
        w_gap_nxt    = r_gap_cnt;
        w_done_nxt   = 1'b0;
        w_accept     = 1'b0;
        w_queue      = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (pg.iTrig || (r_pend != '0)) begin
                    w_accept   = 1'b1;
                    w_wlat_nxt = w_wid_eff;
                    if (pg.iDelay == '0) begin
                        w_state_nxt  = S_ACTIVE;
                        w_active_nxt = 1'b1;
                        w_wid_nxt    = w_wid_eff;
                    end else begin
                        w_state_nxt = S_DELAY;
                        w_dly_nxt   = pg.iDelay;
                    end
                end
            end

            S_DELAY: begin
                w_queue = pg.iTrig;
                if (r_dly_cnt <= DLY_W'(1)) begin
                    w_dly_nxt    = '0;
                    w_state_nxt  = S_ACTIVE;
                    w_active_nxt = 1'b1;
                    w_wid_nxt    = r_wid_lat;
                end else begin
                    w_dly_nxt = r_dly_cnt - DLY_W'(1);
                end
            end

            S_ACTIVE: begin
                w_queue = pg.iTrig & ~w_retrig;
                if (w_retrig) begin
                    w_wid_nxt = w_wid_eff;
                end else if (r_wid_cnt <= WID_W'(1)) begin
                    // Pulse ends here; oDone shows in the first inactive cycle.
                    w_wid_nxt    = '0;
                    w_active_nxt = 1'b0;
                    w_done_nxt   = 1'b1;
                    if (c_HAS_GAP) begin
                        w_state_nxt = S_GAP;
                        w_gap_nxt   = c_GAP_LOAD;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end else begin
                    w_wid_nxt = r_wid_cnt - WID_W'(1);
                end
            end

            S_GAP: begin
                w_queue = pg.iTrig;
                if (r_gap_cnt <= c_GAP_W'(1)) begin
                    w_gap_nxt   = '0;
                    w_state_nxt = S_IDLE;
                end else begin
                    w_gap_nxt = r_gap_cnt - c_GAP_W'(1);
                end
            end

            default: begin
                w_state_nxt  = S_IDLE;
                w_active_nxt = 1'b0;
            end
        endcase
    end

    // A replay that coincides with a fresh trigger leaves the count unchanged.
    always_comb begin
        w_pend_nxt = r_pend;
        w_lose     = 1'b0;
        if (w_queue) begin
            if (r_pend == c_PEND_MAX) begin
                w_lose = 1'b1;
            end else begin
                w_pend_nxt = r_pend + PEND_W'(1);
            end
        end else if (w_accept && (r_pend != '0) && !pg.iTrig) begin
            w_pend_nxt = r_pend - PEND_W'(1);
        end
    end

    always_comb begin
        w_ovf_nxt = r_ovf;
        if (w_lose) begin
            w_ovf_nxt = 1'b1;
        end else if (pg.iClrOvf) begin
            w_ovf_nxt = 1'b0;
        end
    end

    assign pg.oPulse    = pg.pos_neg ? r_active : ~r_active;
    assign pg.oBusy     = r_busy;
    assign pg.oDone     = r_done;
    assign pg.oOverflow = r_ovf;

endmodule

`default_nettype wire
